// File: rtl/pipe_seq_if.sv
// pipe_seq_if: control, hazard and trace signals between the core and its pipeline sequencer.
interface pipe_seq_if #(parameter int ID_W = 32);
    logic            fetch_v;
    logic [4:0]      i_rs1, i_rs2;
    logic            i_use_rs1, i_use_rs2;
    logic            x_load;
    logic [4:0]      x_rd;
    logic            x_busy, m_busy, br_taken;
    logic            fetch_rdy, en_x, en_m, flush;
    logic            inst_v_i, inst_v_x, inst_v_m, inst_v_r;
    logic [ID_W-1:0] ci, cx, cm, cr;
    logic            kill_v;
    logic [ID_W-1:0] ck, retire_cnt;
    modport master (
        output fetch_v, i_rs1, i_rs2, i_use_rs1, i_use_rs2, x_load, x_rd, x_busy, m_busy, br_taken,
        input  fetch_rdy, en_x, en_m, flush, inst_v_i, inst_v_x, inst_v_m, inst_v_r,
        input  ci, cx, cm, cr, kill_v, ck, retire_cnt
    );
    modport slave (
        input  fetch_v, i_rs1, i_rs2, i_use_rs1, i_use_rs2, x_load, x_rd, x_busy, m_busy, br_taken,
        output fetch_rdy, en_x, en_m, flush, inst_v_i, inst_v_x, inst_v_m, inst_v_r,
        output ci, cx, cm, cr, kill_v, ck, retire_cnt
    );
endinterface

// File: rtl/pipe_seq.sv
// pipe_seq: I/X/M/R stage-valid and ID tracking with load-use, hold and branch-squash control.
module pipe_seq #(parameter int ID_W = 32) (
    input logic       clk,
    input logic       reset,
    pipe_seq_if.slave bus
);
    logic            v_i, v_x, v_m;
    logic [ID_W-1:0] next_id;
    logic            hold_m, hold_x, dep, hazard, redirect, hold_i, mv_ix, mv_xm, mv_mr;
    always_comb begin
        hold_m   = v_m & bus.m_busy;
        hold_x   = v_x & (bus.x_busy | hold_m);
        dep      = (bus.i_use_rs1 & (bus.i_rs1 == bus.x_rd)) | (bus.i_use_rs2 & (bus.i_rs2 == bus.x_rd));
        hazard   = v_i & v_x & bus.x_load & (bus.x_rd != 5'd0) & dep;
        redirect = v_x & ~hold_x & bus.br_taken;
        hold_i   = v_i & (hold_x | hazard) & ~redirect;
        mv_ix    = v_i & ~hold_i & ~redirect;
        mv_xm    = v_x & ~hold_x;
        mv_mr    = v_m & ~bus.m_busy;
    end
    // I frees up either when empty or when its occupant moves on this cycle
    assign bus.fetch_rdy = bus.fetch_v & ~redirect & ~hold_i;
    assign bus.en_x      = mv_ix;
    assign bus.en_m      = mv_xm;
    assign bus.flush     = redirect & v_i;
    always_ff @(posedge clk) begin
        if (!reset) begin
            v_i            <= 1'b0;
            v_x            <= 1'b0;
            v_m            <= 1'b0;
            next_id        <= '0;
            bus.inst_v_i   <= 1'b0;
            bus.inst_v_x   <= 1'b0;
            bus.inst_v_m   <= 1'b0;
            bus.inst_v_r   <= 1'b0;
            bus.kill_v     <= 1'b0;
            bus.ci         <= '0;
            bus.cx         <= '0;
            bus.cm         <= '0;
            bus.cr         <= '0;
            bus.ck         <= '0;
            bus.retire_cnt <= '0;
        end else begin
            bus.inst_v_i <= bus.fetch_rdy;
            bus.inst_v_x <= mv_ix;
            bus.inst_v_m <= mv_xm;
            bus.inst_v_r <= mv_mr;
            bus.kill_v   <= bus.flush;
            if (bus.flush)
                bus.ck <= bus.ci;
            if (bus.fetch_rdy) begin
                v_i     <= 1'b1;
                bus.ci  <= next_id;
                next_id <= next_id + 1'b1;
            end else if (mv_ix | redirect)
                v_i <= 1'b0;
            // X empties into a bubble whenever it moves on without a successor
            if (mv_ix) begin
                v_x    <= 1'b1;
                bus.cx <= bus.ci;
            end else if (!hold_x)
                v_x <= 1'b0;
            if (mv_xm) begin
                v_m    <= 1'b1;
                bus.cm <= bus.cx;
            end else if (!hold_m)
                v_m <= 1'b0;
            if (mv_mr) begin
                bus.cr         <= bus.cm;
                bus.retire_cnt <= bus.retire_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_seq.sv
// tb_pipe_seq: directed scenario tasks plus a randomized run against an occupancy-table model of the pipe.
module tb_pipe_seq;
    localparam int AN = 4096;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [4:0] a_rs1 [AN];
    logic [4:0] a_rs2 [AN];
    logic [4:0] a_rd  [AN];
    bit         a_u1  [AN];
    bit         a_u2  [AN];
    bit         a_ld  [AN];
    bit         a_br  [AN];

    pipe_seq_if #(.ID_W(32)) bus();
    pipe_seq #(.ID_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.fetch_v   = 1'b0;
        bus.i_rs1     = '0;
        bus.i_rs2     = '0;
        bus.i_use_rs1 = 1'b0;
        bus.i_use_rs2 = 1'b0;
        bus.x_load    = 1'b0;
        bus.x_rd      = '0;
        bus.x_busy    = 1'b0;
        bus.m_busy    = 1'b0;
        bus.br_taken  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r, bus.kill_v} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b exp 00000", {bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r, bus.kill_v});
        end
        checks++;
        if (bus.retire_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_retire got %0d exp 0", bus.retire_cnt);
        end
        checks++;
        if ({bus.ci, bus.cx, bus.cm, bus.cr, bus.ck} !== 160'd0) begin
            errors++;
            $display("FAIL reset_ids got %h/%h/%h/%h/%h exp all 0", bus.ci, bus.cx, bus.cm, bus.cr, bus.ck);
        end
        bus.fetch_v = 1'b1;
        #1;
        checks++;
        if ({bus.fetch_rdy, bus.flush, bus.en_x, bus.en_m} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_comb got %b exp 1000", {bus.fetch_rdy, bus.flush, bus.en_x, bus.en_m});
        end
    endtask

    task automatic test_stream();
        bit vi, vx, vm, vr;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            bus.fetch_v = (c < 5);
            #1;
            checks++;
            if (bus.fetch_rdy !== (c < 5)) begin
                errors++;
                $display("FAIL stream_fetch_rdy c=%0d got %b exp %b", c, bus.fetch_rdy, c < 5);
            end
            tick();
            vi = (c + 1 >= 1) && (c + 1 <= 5);
            vx = (c + 1 >= 2) && (c + 1 <= 6);
            vm = (c + 1 >= 3) && (c + 1 <= 7);
            vr = (c + 1 >= 4) && (c + 1 <= 8);
            checks++;
            if ({bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r} !== {vi, vx, vm, vr}) begin
                errors++;
                $display("FAIL stream_pulses cyc=%0d got %b exp %b", c + 1,
                         {bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r}, {vi, vx, vm, vr});
            end
            if (vi) begin
                checks++;
                if (bus.ci !== 32'(c)) begin
                    errors++;
                    $display("FAIL stream_ci cyc=%0d got %0d exp %0d", c + 1, bus.ci, c);
                end
            end
            if (vr) begin
                checks++;
                if (bus.cr !== 32'(c - 3)) begin
                    errors++;
                    $display("FAIL stream_cr cyc=%0d got %0d exp %0d", c + 1, bus.cr, c - 3);
                end
            end
        end
        checks++;
        if (bus.retire_cnt !== 32'd5) begin
            errors++;
            $display("FAIL stream_retire got %0d exp 5", bus.retire_cnt);
        end
    endtask

    task automatic test_load_use(input logic [4:0] rd);
        bit st;
        st = (rd != 5'd0);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            bus.fetch_v   = 1'b1;
            bus.x_load    = (c == 2);
            bus.x_rd      = (c == 2) ? rd : 5'd0;
            bus.i_use_rs1 = (c == 2);
            bus.i_rs1     = (c == 2) ? rd : 5'd0;
            #1;
            if (c == 2) begin
                checks++;
                if ({bus.fetch_rdy, bus.en_x} !== {~st, ~st}) begin
                    errors++;
                    $display("FAIL lu_comb rd=%0d got %b exp %b", rd, {bus.fetch_rdy, bus.en_x}, {~st, ~st});
                end
            end
            tick();
            if (c == 2) begin
                checks++;
                if ({bus.inst_v_i, bus.inst_v_x, bus.inst_v_m} !== {~st, ~st, 1'b1}) begin
                    errors++;
                    $display("FAIL lu_bubble rd=%0d got %b exp %b", rd, {bus.inst_v_i, bus.inst_v_x, bus.inst_v_m}, {~st, ~st, 1'b1});
                end
                checks++;
                if (bus.cm !== 32'd0) begin
                    errors++;
                    $display("FAIL lu_cm rd=%0d got %0d exp 0", rd, bus.cm);
                end
            end
            if (c == 3) begin
                checks++;
                if ({bus.inst_v_i, bus.inst_v_x} !== 2'b11) begin
                    errors++;
                    $display("FAIL lu_resume rd=%0d got %b exp 11", rd, {bus.inst_v_i, bus.inst_v_x});
                end
                checks++;
                if ({bus.cx, bus.ci} !== (st ? {32'd1, 32'd2} : {32'd2, 32'd3})) begin
                    errors++;
                    $display("FAIL lu_ids rd=%0d got cx=%0d ci=%0d exp cx=%0d ci=%0d", rd, bus.cx, bus.ci, st ? 1 : 2, st ? 2 : 3);
                end
            end
        end
        idle();
    endtask

    task automatic test_mem_stall();
        do_reset();
        bus.fetch_v = 1'b1;
        for (int c = 0; c < 7; c++) begin
            bus.m_busy = (c >= 3) && (c <= 5);
            #1;
            if (bus.m_busy) begin
                checks++;
                if ({bus.fetch_rdy, bus.en_x, bus.en_m} !== 3'b000) begin
                    errors++;
                    $display("FAIL mstall_comb c=%0d got %b exp 000", c, {bus.fetch_rdy, bus.en_x, bus.en_m});
                end
            end
            tick();
            if (c >= 3 && c <= 5) begin
                checks++;
                if ({bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r} !== 4'b0000) begin
                    errors++;
                    $display("FAIL mstall_pulses cyc=%0d got %b exp 0000", c + 1, {bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r});
                end
                checks++;
                if ({bus.ci, bus.cx, bus.cm} !== {32'd2, 32'd1, 32'd0}) begin
                    errors++;
                    $display("FAIL mstall_ids cyc=%0d got %0d/%0d/%0d exp 2/1/0", c + 1, bus.ci, bus.cx, bus.cm);
                end
            end
            if (c == 6) begin
                checks++;
                if ({bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r} !== 4'b1111) begin
                    errors++;
                    $display("FAIL mstall_release got %b exp 1111", {bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r});
                end
                checks++;
                if ({bus.ci, bus.cx, bus.cm, bus.cr, bus.retire_cnt} !== {32'd3, 32'd2, 32'd1, 32'd0, 32'd1}) begin
                    errors++;
                    $display("FAIL mstall_order got %0d/%0d/%0d/%0d rc=%0d exp 3/2/1/0 rc=1", bus.ci, bus.cx, bus.cm, bus.cr, bus.retire_cnt);
                end
            end
        end
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        bus.fetch_v = 1'b1;
        for (int c = 0; c < 7; c++) begin
            bus.br_taken = (c == 4);
            #1;
            if (c == 4) begin
                checks++;
                if ({bus.flush, bus.fetch_rdy, bus.en_x, bus.en_m} !== 4'b1001) begin
                    errors++;
                    $display("FAIL br_comb got %b exp 1001", {bus.flush, bus.fetch_rdy, bus.en_x, bus.en_m});
                end
            end
            tick();
            if (c == 4) begin
                checks++;
                if ({bus.kill_v, bus.inst_v_i, bus.inst_v_x, bus.inst_v_m} !== 4'b1001) begin
                    errors++;
                    $display("FAIL br_kill got %b exp 1001", {bus.kill_v, bus.inst_v_i, bus.inst_v_x, bus.inst_v_m});
                end
                checks++;
                if ({bus.ck, bus.cm} !== {32'd3, 32'd2}) begin
                    errors++;
                    $display("FAIL br_ck got ck=%0d cm=%0d exp ck=3 cm=2", bus.ck, bus.cm);
                end
            end
            if (c == 5) begin
                checks++;
                if ({bus.kill_v, bus.inst_v_i, bus.inst_v_x, bus.inst_v_r} !== 4'b0101) begin
                    errors++;
                    $display("FAIL br_after got %b exp 0101", {bus.kill_v, bus.inst_v_i, bus.inst_v_x, bus.inst_v_r});
                end
                checks++;
                if ({bus.ci, bus.cr, bus.retire_cnt} !== {32'd4, 32'd2, 32'd3}) begin
                    errors++;
                    $display("FAIL br_ids got ci=%0d cr=%0d rc=%0d exp 4/2/3", bus.ci, bus.cr, bus.retire_cnt);
                end
            end
            if (c == 6) begin
                checks++;
                if ({bus.inst_v_x, bus.cx} !== {1'b1, 32'd4}) begin
                    errors++;
                    $display("FAIL br_next_x got v=%b cx=%0d exp v=1 cx=4", bus.inst_v_x, bus.cx);
                end
            end
        end
        idle();
    endtask

    task automatic test_branch_busy();
        do_reset();
        bus.fetch_v = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.x_busy    = (c == 4) || (c == 5);
            bus.br_taken  = (c >= 4) && (c <= 6);
            bus.x_load    = (c == 6);
            bus.x_rd      = (c == 6) ? 5'd7 : 5'd0;
            bus.i_use_rs2 = (c == 6);
            bus.i_rs2     = 5'd7;
            #1;
            if (c == 4 || c == 5) begin
                checks++;
                if ({bus.flush, bus.fetch_rdy, bus.en_x, bus.en_m} !== 4'b0000) begin
                    errors++;
                    $display("FAIL brbusy_held c=%0d got %b exp 0000", c, {bus.flush, bus.fetch_rdy, bus.en_x, bus.en_m});
                end
            end
            if (c == 6) begin
                checks++;
                if ({bus.flush, bus.fetch_rdy, bus.en_x, bus.en_m} !== 4'b1001) begin
                    errors++;
                    $display("FAIL brbusy_redir got %b exp 1001", {bus.flush, bus.fetch_rdy, bus.en_x, bus.en_m});
                end
            end
            tick();
            if (c == 4 || c == 5) begin
                checks++;
                if (bus.kill_v !== 1'b0) begin
                    errors++;
                    $display("FAIL brbusy_nokill cyc=%0d got %b exp 0", c + 1, bus.kill_v);
                end
            end
            if (c == 6) begin
                checks++;
                if ({bus.kill_v, bus.inst_v_x, bus.inst_v_m, bus.ck, bus.cm} !== {3'b101, 32'd3, 32'd2}) begin
                    errors++;
                    $display("FAIL brbusy_kill got k=%b vx=%b vm=%b ck=%0d cm=%0d exp 1/0/1/3/2",
                             bus.kill_v, bus.inst_v_x, bus.inst_v_m, bus.ck, bus.cm);
                end
            end
            if (c == 7) begin
                checks++;
                if ({bus.inst_v_i, bus.ci} !== {1'b1, 32'd4}) begin
                    errors++;
                    $display("FAIL brbusy_refetch got v=%b ci=%0d exp v=1 ci=4", bus.inst_v_i, bus.ci);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus.fetch_v = 1'b1;
        for (int c = 0; c < 5; c++) begin
            reset        = (c != 4);
            bus.br_taken = (c == 4);
            tick();
            if (c == 3) begin
                checks++;
                if (bus.inst_v_r !== 1'b1) begin
                    errors++;
                    $display("FAIL midrst_full got r=%b exp 1", bus.inst_v_r);
                end
            end
        end
        checks++;
        if ({bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r, bus.kill_v, bus.retire_cnt} !== 37'd0) begin
            errors++;
            $display("FAIL midrst_clear got %b rc=%0d exp 00000 rc=0",
                     {bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r, bus.kill_v}, bus.retire_cnt);
        end
        checks++;
        if ({bus.ci, bus.cx, bus.cm, bus.cr, bus.ck} !== 160'd0) begin
            errors++;
            $display("FAIL midrst_ids got %0d/%0d/%0d/%0d/%0d exp all 0", bus.ci, bus.cx, bus.cm, bus.cr, bus.ck);
        end
        reset        = 1'b1;
        bus.br_taken = 1'b0;
        tick();
        checks++;
        if ({bus.inst_v_i, bus.ci} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL midrst_first got v=%b ci=%0d exp v=1 ci=0", bus.inst_v_i, bus.ci);
        end
        idle();
    endtask

    // Model: st[s] is the ID occupying stage s (-1 empty); an entry pulse is a new ID arriving.
    task automatic test_random();
        int st[4];
        int n[4];
        int nid, rc, ii, xi;
        bit fv, fpend, xb, mb, rst_now, m_stall, x_go, redir, lu, x_stuck, i_go, take, fl;
        bit [4:0] pv;
        logic [31:0] got [4];
        do_reset();
        st = '{-1, -1, -1, -1};
        nid = 0;
        rc = 0;
        fpend = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            fv      = fpend || ($urandom_range(0, 3) != 0);
            xb      = ($urandom_range(0, 4) == 0);
            mb      = ($urandom_range(0, 4) == 0);
            rst_now = ($urandom_range(0, 599) == 0);
            ii      = (st[0] >= 0) ? st[0] % AN : 0;
            xi      = (st[1] >= 0) ? st[1] % AN : 0;
            reset       = !rst_now;
            bus.fetch_v = fv;
            bus.x_busy  = xb;
            bus.m_busy  = mb;
            if (st[0] >= 0) begin
                bus.i_rs1 = a_rs1[ii]; bus.i_rs2 = a_rs2[ii]; bus.i_use_rs1 = a_u1[ii]; bus.i_use_rs2 = a_u2[ii];
            end else begin
                bus.i_rs1 = 5'($urandom); bus.i_rs2 = 5'($urandom); bus.i_use_rs1 = 1'($urandom); bus.i_use_rs2 = 1'($urandom);
            end
            if (st[1] >= 0) begin
                bus.x_load = a_ld[xi]; bus.x_rd = a_rd[xi]; bus.br_taken = a_br[xi];
            end else begin
                bus.x_load = 1'($urandom); bus.x_rd = 5'($urandom); bus.br_taken = 1'($urandom);
            end
            m_stall = (st[2] >= 0) && mb;
            x_go    = (st[1] >= 0) && !xb && !m_stall;
            x_stuck = (st[1] >= 0) && !x_go;
            redir   = x_go && a_br[xi];
            lu      = (st[0] >= 0) && (st[1] >= 0) && a_ld[xi] && (a_rd[xi] != 0) &&
                      ((a_u1[ii] && a_rs1[ii] == a_rd[xi]) || (a_u2[ii] && a_rs2[ii] == a_rd[xi]));
            i_go    = (st[0] >= 0) && !redir && !lu && !x_stuck;
            take    = fv && !redir && ((st[0] < 0) || i_go);
            fl      = redir && (st[0] >= 0);
            #1;
            checks++;
            if ({bus.fetch_rdy, bus.flush, bus.en_x, bus.en_m} !== {take, fl, i_go, x_go}) begin
                errors++;
                $display("FAIL rnd_comb c=%0d got %b exp %b", c, {bus.fetch_rdy, bus.flush, bus.en_x, bus.en_m}, {take, fl, i_go, x_go});
            end
            fpend = fv && !take;
            if (rst_now) begin
                n = '{-1, -1, -1, -1};
                nid = 0;
                rc = 0;
                pv = 5'b0;
            end else begin
                n[3] = ((st[2] >= 0) && !mb) ? st[2] : -1;
                n[2] = m_stall ? st[2] : (x_go ? st[1] : -1);
                n[1] = x_stuck ? st[1] : (i_go ? st[0] : -1);
                n[0] = take ? nid : ((i_go || redir) ? -1 : st[0]);
                if (take) begin
                    a_rs1[nid % AN] = 5'($urandom_range(0, 3));
                    a_rs2[nid % AN] = 5'($urandom_range(0, 3));
                    a_rd[nid % AN]  = 5'($urandom_range(0, 3));
                    a_u1[nid % AN]  = 1'($urandom);
                    a_u2[nid % AN]  = 1'($urandom);
                    a_ld[nid % AN]  = ($urandom_range(0, 2) == 0);
                    a_br[nid % AN]  = ($urandom_range(0, 5) == 0);
                    nid++;
                end
                for (int s = 0; s < 4; s++)
                    pv[4 - s] = (n[s] >= 0) && (n[s] != st[s]);
                pv[0] = fl;
                if (n[3] >= 0)
                    rc++;
            end
            tick();
            checks++;
            if ({bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r, bus.kill_v} !== pv) begin
                errors++;
                $display("FAIL rnd_pulses c=%0d got %b exp %b", c,
                         {bus.inst_v_i, bus.inst_v_x, bus.inst_v_m, bus.inst_v_r, bus.kill_v}, pv);
            end
            got = '{bus.ci, bus.cx, bus.cm, bus.cr};
            for (int s = 0; s < 4; s++) begin
                if (n[s] >= 0) begin
                    checks++;
                    if (got[s] !== 32'(n[s])) begin
                        errors++;
                        $display("FAIL rnd_id c=%0d stage=%0d got %0d exp %0d", c, s, got[s], n[s]);
                    end
                end
            end
            if (pv[0]) begin
                checks++;
                if (bus.ck !== 32'(st[0])) begin
                    errors++;
                    $display("FAIL rnd_ck c=%0d got %0d exp %0d", c, bus.ck, st[0]);
                end
            end
            checks++;
            if (bus.retire_cnt !== 32'(rc)) begin
                errors++;
                $display("FAIL rnd_retire c=%0d got %0d exp %0d", c, bus.retire_cnt, rc);
            end
            st = n;
        end
        reset = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_stream();
        test_load_use(5'd5);
        test_load_use(5'd0);
        test_mem_stall();
        test_branch();
        test_branch_busy();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_seq.md
# pipe_seq

Four-stage in-order pipeline sequencer for the RV32I core. It owns the stage-valid and instruction-ID state for the I (fetch/decode), X (execute), M (memory) and R (retire) stages. It resolves load-use hazards, X/M hold requests and taken-branch squashes. Its per-stage entry pulses and IDs feed the trace/Konata logger directly (inst_v_i/x/m/r, ci/cx/cm/cr) and gate the datapath pipeline registers.

## Interface
- ID_W, 32, width of instruction IDs and of the retire counter
- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-low
- fetch_v  in  1  instruction word presented to I this cycle
- i_rs1, i_rs2  in  5 each  source registers of the instruction currently in I
- i_use_rs1, i_use_rs2  in  1 each  I-stage instruction reads that source
- x_load  in  1  X-stage instruction is a load
- x_rd  in  5  destination register of X-stage instruction
- x_busy  in  1  X needs another cycle (multi-cycle op)
- m_busy  in  1  M waiting on data memory
- br_taken  in  1  X-stage instruction redirects PC; ignored unless X valid and not held
- fetch_rdy  out  1  fetch_v accepted this cycle (fetch may advance PC)
- en_x, en_m  out  1 each  load enable for X / M datapath registers
- flush  out  1  I-stage contents squashed this cycle
- inst_v_i, inst_v_x, inst_v_m, inst_v_r  out  1 each  first cycle an instruction occupies that stage
- ci, cx, cm, cr  out  ID_W each  ID of instruction in I/X/M/R
- kill_v  out  1  a squashed instruction leaves the pipe this cycle
- ck  out  ID_W  ID of the squashed instruction
- retire_cnt  out  ID_W  number of retired instructions

## Operation
- State: v_i/v_x/v_m/v_r, id_i/id_x/id_m/id_r, new-entry flags, next_id counter, retire_cnt.
- Combinational control, evaluated on current state:
  - hold_m = v_m & m_busy
  - hold_x = v_x & (x_busy | hold_m)
  - hazard = v_i & v_x & x_load & (x_rd != 0) & ((i_use_rs1 & i_rs1 == x_rd) | (i_use_rs2 & i_rs2 == x_rd))
  - redirect = v_x & ~hold_x & br_taken
  - hold_i = v_i & (hold_x | hazard) & ~redirect
- Transfers:
  - I→X when v_i & ~hold_i & ~redirect.
  - X→M when v_x & ~hold_x.
  - M→R when v_m & ~m_busy.
  - R always empties after one cycle.
- Bubbles: a hazard inserts a bubble into X (v_x cleared if X moves on). A held M with X not moving keeps X.
- Fetch: fetch_rdy = fetch_v & ~redirect & (~v_i | ~hold_i). An accepted word enters I with id_i = next_id, and next_id increments. fetch_v without fetch_rdy requires the source to hold the same word.
- Redirect: flush = redirect & v_i.
  - The I instruction is dropped; kill_v=1 next cycle with ck = its ID.
  - Any word presented on fetch_v that cycle is refused.
  - The branch itself proceeds to M.
- Outputs:
  - inst_v_s = 1 only in the first cycle an ID is in stage s; held cycles show 0.
  - c* hold the stage ID whenever the stage is valid.
  - retire_cnt increments on every inst_v_r.
- Priority on simultaneous events: redirect > hazard > hold.
- IDs and retire_cnt wrap modulo 2^ID_W.

## Timing
- Reset (reset=0 at posedge): all valids, entry pulses, kill_v, flush, fetch_rdy-related state and IDs = 0; next_id = 0; retire_cnt = 0. In-flight instructions vanish without kill_v.
- Fetch_rdy, en_x, en_m and flush are combinational from current state plus inputs. Every other output is registered.
- No-stall latency, fetch accepted at cycle n:
  - inst_v_i at n+1
  - inst_v_x at n+2
  - inst_v_m at n+3
  - inst_v_r at n+4
- Throughput: one instruction per cycle.
- Load-use: one bubble; the dependent instruction's inst_v_x is delayed exactly 1 cycle.
- m_busy for k cycles stretches M occupancy by k. X and I back up behind it, with no loss and no duplicate entry pulses.
- kill_v is a single-cycle pulse, one cycle after flush.

## Test plan
- Reset, then fetch_v=1 for 5 cycles, no stalls -> IDs 0..4 appear on inst_v_i at cycles 1..5, inst_v_r at cycles 4..8, retire_cnt=5.
- Load in X with x_rd=5, next instruction uses rs1=5 -> hold_i for 1 cycle, bubble in X, dependent inst_v_x 1 cycle late; with x_rd=0 -> no stall.
- m_busy high 3 cycles with full pipe -> M/X/I held 3 cycles, fetch_rdy=0 during hold, no repeated inst_v_* pulses, order and IDs preserved.
- br_taken with ID 2 in X and ID 3 in I -> flush=1, fetch_rdy=0 that cycle, kill_v with ck=3 next cycle, ID 2 retires, next fetched word gets ID 4.
- br_taken while x_busy=1 -> ignored until x_busy drops; redirect coincident with hazard -> I killed, no stall.
- Assert reset mid-stream with 4 valid stages -> all outputs 0 next cycle, first post-reset fetch gets ID 0.
